// File: rtl/even_odd_pkg.sv
// Shared types and default settings for the even/odd weighted round-robin read scheduler.
package even_odd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_EVEN,
        SERVE_ODD
    } sched_state_t;

    typedef enum logic {
        SIDE_EVEN,
        SIDE_ODD
    } side_t;

    localparam int unsigned DEFAULT_EVEN_WEIGHT = 1;
    localparam int unsigned DEFAULT_ODD_WEIGHT  = 1;

    function automatic sched_state_t serve_state(side_t s);
        return (s == SIDE_ODD) ? SERVE_ODD : SERVE_EVEN;
    endfunction

    function automatic side_t other_side(side_t s);
        return (s == SIDE_ODD) ? SIDE_EVEN : SIDE_ODD;
    endfunction

endpackage

// File: rtl/even_odd_wrr_sched.sv
// Work-conserving weighted round-robin drain of the even/odd FWFT FIFOs into one
// registered valid/ready stream; per-class burst length is latched at each burst start.
module even_odd_wrr_sched #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_en,
    input  logic [WEIGHT_W-1:0] cfg_even_weight,
    input  logic [WEIGHT_W-1:0] cfg_odd_weight,
    input  logic                even_empty,
    input  logic [DATA_W-1:0]   even_rd_data,
    output logic                even_rd_en,
    input  logic                odd_empty,
    input  logic [DATA_W-1:0]   odd_rd_data,
    output logic                odd_rd_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_is_odd,
    output logic                busy
);
    import even_odd_pkg::*;

    localparam logic [WEIGHT_W:0]   CNT_ONE = 1;
    localparam logic [WEIGHT_W-1:0] LIM_ONE = 1;

    sched_state_t        state, state_nxt;
    logic [WEIGHT_W:0]   burst_cnt, burst_cnt_nxt;
    logic [WEIGHT_W-1:0] burst_lim, burst_lim_nxt;
    side_t               last_served, last_served_nxt;

    logic                load;
    logic                burst_open;
    side_t               pref;
    logic                pref_avail;
    logic                other_avail;
    logic                grant_valid;
    side_t               grant;
    logic [WEIGHT_W-1:0] grant_weight;

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt       = state;
        burst_cnt_nxt   = burst_cnt;
        burst_lim_nxt   = burst_lim;
        last_served_nxt = last_served;
        pref            = SIDE_EVEN;

        // Held in reset, the registers could not capture a popped word, so no pops.
        load       = reset_n && cfg_en && (!out_valid || out_ready);
        burst_open = (burst_cnt < {1'b0, burst_lim});

        case (state)
            IDLE:       pref = other_side(last_served);
            SERVE_EVEN: pref = burst_open ? SIDE_EVEN : SIDE_ODD;
            SERVE_ODD:  pref = burst_open ? SIDE_ODD : SIDE_EVEN;
            default:    pref = SIDE_EVEN;
        endcase

        pref_avail   = (pref == SIDE_EVEN) ? !even_empty : !odd_empty;
        other_avail  = (pref == SIDE_EVEN) ? !odd_empty : !even_empty;
        grant_valid  = load && (pref_avail || other_avail);
        grant        = pref_avail ? pref : other_side(pref);
        grant_weight = (grant == SIDE_ODD) ? cfg_odd_weight : cfg_even_weight;

        even_rd_en = grant_valid && (grant == SIDE_EVEN);
        odd_rd_en  = grant_valid && (grant == SIDE_ODD);

        if (grant_valid) begin
            if (state == serve_state(grant) && burst_open) begin
                burst_cnt_nxt = burst_cnt + CNT_ONE;
            end else begin
                state_nxt     = serve_state(grant);
                burst_cnt_nxt = CNT_ONE;
                burst_lim_nxt = (grant_weight == '0) ? LIM_ONE : grant_weight;
            end
            last_served_nxt = grant;
        end else if (!cfg_en || load) begin
            // Disabled, or free to pop with nothing to pop: fall back to IDLE.
            state_nxt     = IDLE;
            burst_cnt_nxt = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            burst_lim   <= LIM_ONE;
            last_served <= SIDE_ODD;
        end else begin
            state       <= state_nxt;
            burst_cnt   <= burst_cnt_nxt;
            burst_lim   <= burst_lim_nxt;
            last_served <= last_served_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_is_odd <= 1'b0;
        end else if (grant_valid) begin
            out_valid  <= 1'b1;
            out_data   <= (grant == SIDE_ODD) ? odd_rd_data : even_rd_data;
            out_is_odd <= (grant == SIDE_ODD);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    assign busy = (state != IDLE) || out_valid;

endmodule
